// File: rtl/video_pkg.sv
// Shared video-path constants: default pixel format, line length and
// the width of the row-fill counter.
package video_pkg;
    localparam int PIX_W_DEF    = 24;
    localparam int LINE_LEN_DEF = 640;
    localparam int ROWS_W       = 4;
endpackage

// File: rtl/line_window_buf_row_ram.sv
// One line of pixel storage: single clock, one write port, one registered
// read port returning the old contents when read and write collide.
module row_ram
    import video_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int LINE_LEN = LINE_LEN_DEF,
    parameter int ADR_W    = 10
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic [PIX_W-1:0] din,
    input  logic [ADR_W-1:0] rd_adr,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] mem [LINE_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_adr] <= din;
        end
        dout <= mem[rd_adr];
    end

endmodule

// File: rtl/line_window_buf.sv
// Vertical window generator: TAPS-1 cascaded row RAMs deliver TAPS vertically
// aligned pixels per accepted input pixel, with fill-aware border masking.
module line_window_buf
    import video_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int LINE_LEN = LINE_LEN_DEF,
    parameter int ADR_W    = 10,
    parameter int TAPS     = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_in_valid,
    input  logic                  sof,
    input  logic                  sol,
    input  logic [PIX_W-1:0]      pix_in,
    input  logic                  border_mode,
    output logic [TAPS*PIX_W-1:0] taps_out,
    output logic                  taps_valid,
    output logic [ROWS_W-1:0]     rows_filled,
    output logic                  line_ovf
);

    localparam int                COL_W    = ADR_W + 1;
    localparam logic [COL_W-1:0]  COL_END  = COL_W'(LINE_LEN);
    localparam logic [ROWS_W-1:0] FILL_MAX = ROWS_W'(TAPS - 1);

    function automatic logic [ROWS_W-1:0] sat_inc(input logic [ROWS_W-1:0] v);
        return (v >= FILL_MAX) ? FILL_MAX : v + ROWS_W'(1);
    endfunction

    logic [COL_W-1:0]  col;
    logic              line_has_pix;
    logic [ROWS_W-1:0] rows;
    logic [ROWS_W-1:0] rows_nxt;
    logic              restart, accept, ovf;
    logic [ADR_W-1:0]  adr_p0;

    logic              vld_p1;
    logic              mode_p1;
    logic [PIX_W-1:0]  pix_p1;
    logic [ADR_W-1:0]  adr_p1;
    logic [ROWS_W-1:0] fill_p1;

    logic [PIX_W-1:0]      ram_dout [TAPS-1];
    logic [PIX_W-1:0]      raw      [TAPS];
    logic [PIX_W-1:0]      edge_pix;
    logic [TAPS*PIX_W-1:0] win_p1;
    logic [TAPS*PIX_W-1:0] hold;

    // ---- stage p0: column addressing, acceptance, fill update
    assign restart = sof | sol;
    assign adr_p0  = restart ? '0 : col[ADR_W-1:0];
    assign accept  = pix_in_valid & (restart | (col < COL_END));
    assign ovf     = pix_in_valid & ~restart & (col >= COL_END);

    // sof wins over sol: a new frame restarts the count instead of advancing it
    always_comb begin
        rows_nxt = rows;
        if (pix_in_valid && sof) begin
            rows_nxt = '0;
        end else if (pix_in_valid && sol && line_has_pix) begin
            rows_nxt = sat_inc(rows);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            line_has_pix <= 1'b0;
            rows         <= '0;
            vld_p1       <= 1'b0;
            line_ovf     <= 1'b0;
            hold         <= '0;
        end else begin
            vld_p1   <= accept;
            line_ovf <= ovf;
            hold     <= taps_out;
            if (accept) begin
                col          <= restart ? COL_W'(1) : col + COL_W'(1);
                line_has_pix <= 1'b1;
                rows         <= rows_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pix_p1  <= pix_in;
            adr_p1  <= adr_p0;
            fill_p1 <= rows_nxt;
            mode_p1 <= border_mode;
        end
    end

    // ---- stage p1: row RAM outputs become taps; each tap shifts one RAM down
    always_comb begin
        raw[0] = pix_p1;
        for (int k = 0; k < TAPS - 1; k++) begin
            raw[k+1] = ram_dout[k];
        end
    end

    for (genvar k = 0; k < TAPS - 1; k++) begin : g_row
        row_ram #(
            .PIX_W   (PIX_W),
            .LINE_LEN(LINE_LEN),
            .ADR_W   (ADR_W)
        ) u_row (
            .clk   (clk),
            .wr_en (vld_p1),
            .wr_adr(adr_p1),
            .din   (raw[k]),
            .rd_adr(adr_p0),
            .dout  (ram_dout[k])
        );
    end

    always_comb begin
        edge_pix = '0;
        win_p1   = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (int'(fill_p1) == k) begin
                edge_pix = raw[k];
            end
        end
        for (int k = 0; k < TAPS; k++) begin
            if (k <= int'(fill_p1)) begin
                win_p1[k*PIX_W +: PIX_W] = raw[k];
            end else if (mode_p1) begin
                win_p1[k*PIX_W +: PIX_W] = edge_pix;
            end
        end
    end

    assign taps_out    = vld_p1 ? win_p1 : hold;
    assign taps_valid  = vld_p1;
    assign rows_filled = rows;

endmodule

// File: tb/tb_line_window_buf.sv
// Bench for line_window_buf: small (TAPS=3, LINE_LEN=4, 8-bit) and full-size
// instances checked against a frame-array reference model.
module tb_line_window_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         s_valid, s_sof, s_sol, s_mode;
    logic [7:0]   s_pix;
    logic [23:0]  s_taps;
    logic         s_tv, s_ovf;
    logic [3:0]   s_rf;

    logic         l_valid, l_sof, l_sol, l_mode;
    logic [23:0]  l_pix;
    logic [263:0] l_taps;
    logic         l_tv, l_ovf;
    logic [3:0]   l_rf;

    int tests = 0;
    int fails = 0;
    int frame [16][4];
    logic [23:0] last_exp_s;

    line_window_buf #(.PIX_W(8), .LINE_LEN(4), .ADR_W(2), .TAPS(3)) dut_s (
        .clk(clk), .rst(rst), .pix_in_valid(s_valid), .sof(s_sof), .sol(s_sol),
        .pix_in(s_pix), .border_mode(s_mode), .taps_out(s_taps),
        .taps_valid(s_tv), .rows_filled(s_rf), .line_ovf(s_ovf)
    );

    line_window_buf #(.PIX_W(24), .LINE_LEN(640), .ADR_W(10), .TAPS(11)) dut_l (
        .clk(clk), .rst(rst), .pix_in_valid(l_valid), .sof(l_sof), .sol(l_sol),
        .pix_in(l_pix), .border_mode(l_mode), .taps_out(l_taps),
        .taps_valid(l_tv), .rows_filled(l_rf), .line_ovf(l_ovf)
    );

    task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window for row r, column c of the current frame: tap k is row r-k,
    // rows not yet seen are zero or a copy of the oldest available row.
    function automatic logic [23:0] exp_s(input int r, input int c, input logic mode);
        int f;
        logic [23:0] w;
        f = (r < 2) ? r : 2;
        w = '0;
        for (int k = 0; k < 3; k++) begin
            if (k <= f) w[k*8 +: 8] = 8'(frame[r-k][c]);
            else if (mode) w[k*8 +: 8] = 8'(frame[r-f][c]);
        end
        return w;
    endfunction

    task automatic px_s(input int r, input int c, input logic [7:0] v,
                        input logic mode, input logic sof, input logic sol);
        frame[r][c] = int'(v);
        s_valid = 1'b1; s_sof = sof; s_sol = sol; s_pix = v; s_mode = mode;
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0; s_sol = 1'b0;
        last_exp_s = exp_s(r, c, mode);
        check($sformatf("tv r%0d c%0d", r, c), 264'(s_tv), 264'(1));
        check($sformatf("taps r%0d c%0d", r, c), 264'(s_taps), 264'(last_exp_s));
        check($sformatf("rows r%0d c%0d", r, c), 264'(s_rf), 264'((r < 2) ? r : 2));
    endtask

    task automatic idle_s(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("idle tv", 264'(s_tv), 264'(0));
            check("idle hold", 264'(s_taps), 264'(last_exp_s));
        end
    endtask

    task automatic line_s(input int r, input logic mode, input logic first, input logic rnd);
        for (int c = 0; c < 4; c++) begin
            px_s(r, c, rnd ? 8'($urandom) : 8'(10*r + c), mode, first && (c == 0), c == 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 0; s_sof = 0; s_sol = 0; s_mode = 0; s_pix = '0;
        l_valid = 0; l_sof = 0; l_sol = 0; l_mode = 0; l_pix = '0;
        last_exp_s = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst taps", 264'(s_taps), 264'(0));
        check("rst tv", 264'(s_tv), 264'(0));
        check("rst rows", 264'(s_rf), 264'(0));
        check("rst ovf", 264'(s_ovf), 264'(0));
        check("rst l_taps", l_taps, 264'(0));
        check("rst l_tv", 264'(l_tv), 264'(0));
        rst = 1'b0;
        idle_s(1);

        // Fill: three rows of 10*row+col
        line_s(0, 1'b0, 1'b1, 1'b0);
        line_s(1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            px_s(2, c, 8'(20 + c), 1'b0, 1'b0, c == 0);
            if (c == 1) check("fill r2c1", 264'(s_taps), 264'({8'd1, 8'd11, 8'd21}));
        end
        idle_s(3);

        // Border: row 0 replicate, row 1 zero-fill
        for (int c = 0; c < 4; c++) begin
            px_s(0, c, 8'(c), 1'b1, c == 0, c == 0);
            if (c == 2) check("border r0 repl", 264'(s_taps), 264'({8'd2, 8'd2, 8'd2}));
        end
        for (int c = 0; c < 4; c++) begin
            px_s(1, c, 8'(10 + c), 1'b0, 1'b0, c == 0);
            if (c == 3) check("border r1c3 zero", 264'(s_taps), 264'({8'd0, 8'd3, 8'd13}));
        end
        line_s(0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            px_s(1, c, 8'(10 + c), c == 3, 1'b0, c == 0);
            if (c == 3) check("border r1c3 repl", 264'(s_taps), 264'({8'd3, 8'd3, 8'd13}));
        end

        // Overflow: fifth pixel on a line without sol
        line_s(0, 1'b0, 1'b1, 1'b1);
        s_valid = 1'b1; s_pix = 8'd99;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("ovf pulse", 264'(s_ovf), 264'(1));
        check("ovf tv", 264'(s_tv), 264'(0));
        check("ovf hold", 264'(s_taps), 264'(last_exp_s));
        @(posedge clk); #1;
        check("ovf one cycle", 264'(s_ovf), 264'(0));
        px_s(1, 0, 8'($urandom), 1'b0, 1'b0, 1'b1);
        check("ovf next col0", 264'(s_taps[15:8]), 264'(frame[0][0]));
        for (int c = 1; c < 4; c++) px_s(1, c, 8'($urandom), 1'b0, 1'b0, 1'b0);

        // Gaps: random data, random idle cycles, random border mode per row
        for (int r = 0; r < 3; r++) begin
            logic m;
            m = 1'($urandom);
            for (int c = 0; c < 4; c++) begin
                idle_s($urandom_range(0, 2));
                px_s(r, c, 8'($urandom), m, (r == 0) && (c == 0), c == 0);
            end
        end

        // Reset mid row 2, then a fresh frame must not expose stale RAM data
        line_s(0, 1'b0, 1'b1, 1'b1);
        line_s(1, 1'b0, 1'b0, 1'b1);
        px_s(2, 0, 8'($urandom), 1'b0, 1'b0, 1'b1);
        px_s(2, 1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        s_valid = 1'b1; s_pix = 8'hA5; rst = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; rst = 1'b0;
        check("midrst taps", 264'(s_taps), 264'(0));
        check("midrst tv", 264'(s_tv), 264'(0));
        check("midrst rows", 264'(s_rf), 264'(0));
        check("midrst ovf", 264'(s_ovf), 264'(0));
        last_exp_s = '0;
        for (int c = 0; c < 4; c++) begin
            px_s(0, c, 8'($urandom_range(1, 255)), 1'b0, c == 0, c == 0);
            if (c == 1) check("postrst zero fill", 264'(s_taps[23:8]), 264'(0));
        end

        // Full size: 12 lines of 640 pixels, pixel = {line, col}
        for (int ln = 0; ln < 12; ln++) begin
            for (int c = 0; c < 640; c++) begin
                l_valid = 1'b1;
                l_sof = (ln == 0) && (c == 0);
                l_sol = (c == 0);
                l_pix = 24'((ln << 16) | c);
                @(posedge clk); #1;
                if (ln == 3 && c == 100) begin
                    check("scale l3 tap3", 264'(l_taps[95:72]), 264'(24'((0 << 16) | 100)));
                    check("scale l3 masked", 264'(l_taps[263:96]), 264'(0));
                    check("scale l3 rows", 264'(l_rf), 264'(3));
                end
                if (ln == 11 && c == 639) begin
                    for (int k = 0; k < 11; k++) begin
                        check($sformatf("scale tap%0d", k), 264'(l_taps[k*24 +: 24]),
                              264'(24'(((11 - k) << 16) | 639)));
                    end
                    check("scale rows sat", 264'(l_rf), 264'(10));
                    check("scale tv", 264'(l_tv), 264'(1));
                end
            end
        end
        l_valid = 1'b0; l_sof = 1'b0; l_sol = 1'b0;
        @(posedge clk); #1;
        check("scale idle tv", 264'(l_tv), 264'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
